// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO sequencer of the iterative mult/div path.
package hilo_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_MT   = 2'b11;

  localparam int unsigned DEF_MAX_CYCLES = 40;
  localparam int unsigned DEF_START_WAIT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitStart,
    StWaitDone,
    StWriteback,
    StError
  } state_e;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: independent write enables, data from move-to or unit writeback.
module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        wb_sel,
  input  logic [31:0] mt_data,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_d, lo_d;

  assign hi_d = wb_sel ? wb_hi : mt_data;
  assign lo_d = wb_sel ? wb_lo : mt_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer for mult/div/move-to requests: launches the unit, watches its busy flag,
// writes HI/LO and traps divide-by-zero and unit hangs.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned START_WAIT = DEF_START_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  op,
  input  logic        op_valid,
  input  logic        mt_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_busy,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_busy,
  output logic        div_control,
  output logic        mult_control,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        div_zero,
  output logic        fu_timeout
);

  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  state_e        state_q;
  logic          is_div_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   cnt_inc;
  logic          busy_sel, accept, div_zero_req, mt_req, wb_fire;

  // Only the unit that was launched is observed.
  assign busy_sel     = is_div_q ? div_busy : mult_busy;
  assign accept       = (state_q == StIdle) && op_valid &&
                        ((op == OP_MULT) || ((op == OP_DIV) && (b != '0)));
  assign div_zero_req = (state_q == StIdle) && op_valid && (op == OP_DIV) && (b == '0);
  assign mt_req       = (state_q == StIdle) && op_valid && (op == OP_MT);
  assign wb_fire      = (state_q == StWaitDone) && !busy_sel;

  assign cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign cnt_next = (cnt_q == CW'(MAX_CYCLES)) ? cnt_q : cnt_inc[CW-1:0];

  // Results are latched on the edge entering WRITEBACK so HI/LO are valid while stall is low.
  assign stall = accept || (state_q == StLaunch) || (state_q == StWaitStart) ||
                 (state_q == StWaitDone) || (state_q == StError);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      is_div_q     <= 1'b0;
      cnt_q        <= '0;
      div_control  <= 1'b0;
      mult_control <= 1'b0;
      done         <= 1'b0;
      div_zero     <= 1'b0;
      fu_timeout   <= 1'b0;
    end else begin
      div_control  <= 1'b0;
      mult_control <= 1'b0;
      done         <= 1'b0;
      div_zero     <= div_zero_req;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_div_q     <= (op == OP_DIV);
            div_control  <= (op == OP_DIV);
            mult_control <= (op == OP_MULT);
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          cnt_q   <= '0;
          state_q <= StWaitStart;
        end
        StWaitStart: begin
          if (busy_sel) begin
            cnt_q   <= '0;
            state_q <= StWaitDone;
          end else if (cnt_inc >= (CW+1)'(START_WAIT)) begin
            fu_timeout <= 1'b1;
            state_q    <= StError;
          end else begin
            cnt_q <= cnt_next;
          end
        end
        StWaitDone: begin
          if (!busy_sel) begin
            done    <= 1'b1;
            state_q <= StWriteback;
          end else if (cnt_inc >= (CW+1)'(MAX_CYCLES)) begin
            fu_timeout <= 1'b1;
            state_q    <= StError;
          end else begin
            cnt_q <= cnt_next;
          end
        end
        StWriteback: state_q <= StIdle;
        StError:     fu_timeout <= 1'b1;
        default:     state_q <= StIdle;
      endcase
    end
  end

  hilo_regs u_regs (
    .clk     (clk),
    .reset   (reset),
    .hi_we   ((mt_req && !mt_sel) || wb_fire),
    .lo_we   ((mt_req && mt_sel) || wb_fire),
    .wb_sel  (wb_fire),
    .mt_data (a),
    .wb_hi   (is_div_q ? div_hi : mult_hi),
    .wb_lo   (is_div_q ? div_lo : mult_lo),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
